dma_copy: RTL
=============

Name: dma_copy

Overview:
- Memory-mapped word-copy engine that closes the loop on the SoC bus.
- Toward the CPU it is a responder, with 4 registers selected by alu_out[3:2] and a write strobe from the address decoder (new decode slot 4'd10, read-mux select index shared with the widened SoC mux).
- Toward data memory it is an initiator: it drives address, write enable and write data into the dmem port when the SoC grants it.
- Copies N words from SRC to DST without CPU involvement.

Parameters:
- AW, 9, byte-address width of the memory port (matches dmem addr[8:0]).
- CW, 8, width of the word counter; max transfer 2^CW-1 words.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- a  in  2  register select (alu_out[3:2]).
- we  in  1  register write strobe from address decoder.
- wd  in  32  register write data.
- rd  out  32  register read data, combinational on a.
- m_gnt  in  1  SoC grants memory port to engine this cycle.
- m_req  out  1  engine requests memory port.
- m_addr  out  AW  memory byte address.
- m_we  out  1  memory write enable.
- m_wd  out  32  memory write data.
- m_rd  in  32  memory read data (dmem async read).
- irq  out  1  transfer-complete interrupt (see Optional Feature).

Behaviour:
- Registers (word index a):
  - 0 SRC: AW bits.
  - 1 DST: AW bits.
  - 2 CNT: CW bits.
  - 3 CTRL/STATUS.
- Reads:
  - Reads zero-extend to 32 bits.
  - SRC, DST and CNT read their live values (they advance during a transfer).
- CTRL write bits:
  - bit0 go.
  - bit1 clear_done.
  - bit2 irq_en (macro only).
- STATUS read bits:
  - bit0 busy.
  - bit1 done.
  - bit2 irq_en (0 without macro).
  - other bits 0.
- Writes to SRC, DST and CNT while busy are ignored. Address bits [1:0] of the written value are forced to 0.
- FSM states: IDLE, RD, WR, FIN.
  - IDLE: go=1 and CNT!=0 -> RD; busy=1 and done cleared that same edge. go=1 and CNT==0 -> FIN.
  - RD: m_req=1, m_addr=SRC, m_we=0. On an edge with m_gnt=1: capture m_rd into data reg, SRC+=4 (mod 2^AW), -> WR. If m_gnt=0, hold RD.
  - WR: m_req=1, m_addr=DST, m_we=m_gnt, m_wd=data reg. On an edge with m_gnt=1: DST+=4, CNT-=1. Go to FIN if CNT was 1, else RD. If m_gnt=0, hold WR with m_we=0.
  - FIN: done=1, busy=0, -> IDLE. Takes one cycle.
- Throughput: 2 cycles/word at full grant. Latency from the go write edge to done=1 is 2N+1 cycles.
- Outside RD/WR: m_req=0, m_we=0, m_addr=0, m_wd=0.
- go while busy is ignored. clear_done while busy has no effect. go and clear_done in the same write: go wins, and done is cleared.
- Address wrap: SRC and DST wrap silently at 2^AW. Overlapping regions copy in ascending order with no hazard protection.
- Reset values:
  - All registers, data reg and done = 0.
  - State = IDLE.
  - All outputs 0.
- Reset mid-transfer aborts immediately: m_we deasserts the same edge and no partial-word write occurs after reset.

Optional Feature:
- Macro: DMA_COPY_IRQ_EN.
- Defined:
  - CTRL bit2 stores irq_en.
  - irq = done & irq_en, registered, so it rises in the cycle after FIN.
  - irq is cleared by clear_done or go.
- Undefined:
  - irq tied 0.
  - bit2 not stored and reads 0.

Decomposition:
- global_types gains:
  - dma_state_t enum (IDLE, RD, WR, FIN).
  - localparams DMA_REG_SRC=0, DMA_REG_DST=1, DMA_REG_CNT=2, DMA_REG_CTRL=3.
  - CTRL/STATUS bit index constants.
- One natural sub-module, dma_copy_regs: register file, write masking while busy, and the read mux.
- The FSM and datapath stay in dma_copy.

Test Plan:
1. SRC=0x040, DST=0x080, CNT=3, go, m_gnt=1, memory preloaded {0xA,0xB,0xC} -> addr 0x080..0x088 = {0xA,0xB,0xC}; done=1 at 7 cycles after go edge; STATUS reads 0x2; CNT reads 0.
2. CNT=0, go -> FIN next cycle, done=1; m_req never asserts; memory unchanged.
3. CNT=2 with m_gnt toggling 1,0,0,1,... -> FSM holds RD/WR on gnt=0; m_we never high when m_gnt=0; final data correct; latency extends by the number of stalled cycles.
4. Mid-transfer: write SRC=0x100 and go -> ignored; copy completes with original SRC; SRC reads original+4N.
5. SRC=0x1FC, DST=0x000, CNT=2 -> second read from 0x000 (wrap); DST ends at 0x008.
6. Assert reset during WR of word 2 of 4 -> next cycle m_we=0, STATUS=0, all regs 0; only word 1 written. With DMA_COPY_IRQ_EN defined: irq_en=1, CNT=1 -> irq=1 one cycle after done; clear_done -> irq=0.

Source files
------------

// File: rtl/dma_copy_pkg.sv
// Shared types and register map for the dma_copy word-copy engine.
// Build with DMA_COPY_IRQ_EN defined to enable the completion interrupt.
package dma_copy_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RD,
    WR,
    FIN
  } dma_state_t;

  localparam logic [1:0] DMA_REG_SRC  = 2'd0;
  localparam logic [1:0] DMA_REG_DST  = 2'd1;
  localparam logic [1:0] DMA_REG_CNT  = 2'd2;
  localparam logic [1:0] DMA_REG_CTRL = 2'd3;

  localparam int CTRL_GO     = 0;
  localparam int CTRL_CLR    = 1;
  localparam int CTRL_IRQ_EN = 2;

  localparam int STAT_BUSY   = 0;
  localparam int STAT_DONE   = 1;
  localparam int STAT_IRQ_EN = 2;

  function automatic logic [31:0] status_word(
    input logic busy,
    input logic done,
    input logic irq_en
  );
    logic [31:0] s;
    s = '0;
    s[STAT_BUSY]   = busy;
    s[STAT_DONE]   = done;
    s[STAT_IRQ_EN] = irq_en;
    return s;
  endfunction

endpackage

// File: rtl/dma_copy_regs.sv
// CPU-visible register file of dma_copy: SRC/DST/CNT, CTRL decode, read mux.
// irq_en is only stored when DMA_COPY_IRQ_EN is defined.
module dma_copy_regs
  import dma_copy_pkg::*;
#(
  parameter int AW = 9,
  parameter int CW = 8
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [1:0]    a,
  input  logic          we,
  input  logic [31:0]   wd,
  input  logic          busy,
  input  logic          done,
  input  logic          src_inc,
  input  logic          dst_inc,
  input  logic          cnt_dec,
  output logic [31:0]   rd,
  output logic [AW-1:0] src,
  output logic [AW-1:0] dst,
  output logic [CW-1:0] cnt,
  output logic          irq_en,
  output logic          go_wr,
  output logic          clr_wr
);

  localparam logic [AW-1:0] STEP = AW'(4);

  logic [AW-1:0] src_q, src_d;
  logic [AW-1:0] dst_q, dst_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          wr_ok;
  logic          ctrl_wr;

  assign wr_ok   = we & ~busy;
  assign ctrl_wr = we && (a == DMA_REG_CTRL);
  assign go_wr   = ctrl_wr & wd[CTRL_GO];
  assign clr_wr  = ctrl_wr & wd[CTRL_CLR];

  always_comb begin
    src_d = src_q;
    dst_d = dst_q;
    cnt_d = cnt_q;
    if (wr_ok && a == DMA_REG_SRC)
      src_d = {wd[AW-1:2], 2'b00};
    else if (src_inc)
      src_d = src_q + STEP;
    if (wr_ok && a == DMA_REG_DST)
      dst_d = {wd[AW-1:2], 2'b00};
    else if (dst_inc)
      dst_d = dst_q + STEP;
    if (wr_ok && a == DMA_REG_CNT)
      cnt_d = wd[CW-1:0];
    else if (cnt_dec)
      cnt_d = cnt_q - CW'(1);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      src_q <= '0;
      dst_q <= '0;
      cnt_q <= '0;
    end else begin
      src_q <= src_d;
      dst_q <= dst_d;
      cnt_q <= cnt_d;
    end
  end

`ifdef DMA_COPY_IRQ_EN
  logic irq_en_q, irq_en_d;

  always_comb begin
    irq_en_d = irq_en_q;
    if (ctrl_wr)
      irq_en_d = wd[CTRL_IRQ_EN];
  end

  always_ff @(posedge clock) begin
    if (reset)
      irq_en_q <= 1'b0;
    else
      irq_en_q <= irq_en_d;
  end

  assign irq_en = irq_en_q;
`else
  assign irq_en = 1'b0;
`endif

  always_comb begin
    rd = '0;
    unique case (a)
      DMA_REG_SRC:  rd = 32'(src_q);
      DMA_REG_DST:  rd = 32'(dst_q);
      DMA_REG_CNT:  rd = 32'(cnt_q);
      DMA_REG_CTRL: rd = status_word(busy, done, irq_en);
    endcase
  end

  assign src = src_q;
  assign dst = dst_q;
  assign cnt = cnt_q;

  logic unused_wd;
  assign unused_wd = ^wd;

endmodule

// File: rtl/dma_copy.sv
// Word-copy DMA engine: CPU register slave, dmem master, RD/WR copy FSM.
// Define DMA_COPY_IRQ_EN for the registered transfer-complete interrupt.
module dma_copy
  import dma_copy_pkg::*;
#(
  parameter int AW = 9,
  parameter int CW = 8
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [1:0]    a,
  input  logic          we,
  input  logic [31:0]   wd,
  output logic [31:0]   rd,
  input  logic          m_gnt,
  output logic          m_req,
  output logic [AW-1:0] m_addr,
  output logic          m_we,
  output logic [31:0]   m_wd,
  input  logic [31:0]   m_rd,
  output logic          irq
);

  dma_state_t    state_q, state_d;
  logic [31:0]   data_q, data_d;
  logic          done_q, done_d;
  logic          busy;
  logic          src_inc, dst_inc, cnt_dec;
  logic          go_wr, clr_wr, irq_en;
  logic [AW-1:0] src, dst;
  logic [CW-1:0] cnt;

  assign busy = (state_q == RD) || (state_q == WR);

  dma_copy_regs #(
    .AW(AW),
    .CW(CW)
  ) u_regs (
    .clock  (clock),
    .reset  (reset),
    .a      (a),
    .we     (we),
    .wd     (wd),
    .busy   (busy),
    .done   (done_q),
    .src_inc(src_inc),
    .dst_inc(dst_inc),
    .cnt_dec(cnt_dec),
    .rd     (rd),
    .src    (src),
    .dst    (dst),
    .cnt    (cnt),
    .irq_en (irq_en),
    .go_wr  (go_wr),
    .clr_wr (clr_wr)
  );

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    done_d  = done_q;
    src_inc = 1'b0;
    dst_inc = 1'b0;
    cnt_dec = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (go_wr) begin
          done_d  = 1'b0;
          state_d = (cnt != '0) ? RD : FIN;
        end else if (clr_wr) begin
          done_d = 1'b0;
        end
      end
      RD: begin
        if (m_gnt) begin
          data_d  = m_rd;
          src_inc = 1'b1;
          state_d = WR;
        end
      end
      WR: begin
        if (m_gnt) begin
          dst_inc = 1'b1;
          cnt_dec = 1'b1;
          state_d = (cnt == CW'(1)) ? FIN : RD;
        end
      end
      FIN: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      data_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    m_req  = 1'b0;
    m_addr = '0;
    m_we   = 1'b0;
    m_wd   = '0;
    unique case (state_q)
      RD: begin
        m_req  = 1'b1;
        m_addr = src;
      end
      WR: begin
        m_req  = 1'b1;
        m_addr = dst;
        // no write may land on the reset edge
        m_we   = m_gnt & ~reset;
        m_wd   = data_q;
      end
      default: ;
    endcase
  end

`ifdef DMA_COPY_IRQ_EN
  logic irq_q, irq_d;

  assign irq_d = done_q & irq_en & ~(go_wr | clr_wr);

  always_ff @(posedge clock) begin
    if (reset)
      irq_q <= 1'b0;
    else
      irq_q <= irq_d;
  end

  assign irq = irq_q;
`else
  logic unused_irq_en;
  assign unused_irq_en = irq_en;
  assign irq = 1'b0;
`endif

endmodule
